// File: rtl/ternary_seq_ctrl.sv
// rtl/ternary_seq_ctrl.sv - job sequencer for a ternary-weight MAC: weight load, per-vector run, result drain
module ternary_seq_ctrl #(
    parameter int MAX_IN_LEN   = 16,
    parameter int MAX_OUT_LEN  = 8,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              cfg_valid,
    input  logic [$clog2(MAX_IN_LEN)-1:0]                     cfg_in_len,
    input  logic [$clog2(MAX_OUT_LEN)-1:0]                    cfg_out_len,
    input  logic [7:0]                                        cfg_num_vec,
    input  logic                                              cfg_reuse,
    input  logic                                              abort,
    output logic                                              load_ena,
    output logic                                              load_phase,
    output logic [$clog2(MAX_IN_LEN)+$clog2(MAX_OUT_LEN)-1:0] load_param,
    input  logic                                              load_done,
    output logic                                              x_ready,
    input  logic                                              x_valid,
    output logic                                              mac_start,
    input  logic                                              mac_done,
    output logic                                              out_valid,
    output logic [$clog2(MAX_OUT_LEN)-1:0]                    out_sel,
    output logic                                              out_last,
    output logic [7:0]                                        vec_idx,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err
);
    localparam int IW = $clog2(MAX_IN_LEN);
    localparam int OW = $clog2(MAX_OUT_LEN);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_X, S_RUN, S_DRAIN} state_t;

    state_t          state_q;
    logic            weights_valid_q;
    logic [CW-1:0]   load_cnt_q;
    logic [IW-1:0]   in_len_q;
    logic [OW-1:0]   out_len_q;
    logic [7:0]      num_vec_q;
    logic            load_ena_q, load_phase_q, x_ready_q, mac_start_q;
    logic            out_valid_q, out_last_q, busy_q, done_q, err_q;
    logic [OW-1:0]   out_sel_q;
    logic [7:0]      vec_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            weights_valid_q <= 1'b0;
            load_cnt_q      <= '0;
            in_len_q        <= '0;
            out_len_q       <= '0;
            num_vec_q       <= '0;
            load_ena_q      <= 1'b0;
            load_phase_q    <= 1'b0;
            x_ready_q       <= 1'b0;
            mac_start_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_sel_q       <= '0;
            out_last_q      <= 1'b0;
            vec_idx_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mac_start_q <= 1'b0;
            if (abort) begin
                // Abort drops the job silently; only a partial load invalidates stored weights
                state_q      <= S_IDLE;
                load_cnt_q   <= '0;
                in_len_q     <= '0;
                out_len_q    <= '0;
                num_vec_q    <= '0;
                load_ena_q   <= 1'b0;
                load_phase_q <= 1'b0;
                x_ready_q    <= 1'b0;
                out_valid_q  <= 1'b0;
                out_sel_q    <= '0;
                out_last_q   <= 1'b0;
                vec_idx_q    <= '0;
                busy_q       <= 1'b0;
                if (state_q == S_LOAD) weights_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            in_len_q   <= cfg_in_len;
                            out_len_q  <= cfg_out_len;
                            num_vec_q  <= cfg_num_vec;
                            vec_idx_q  <= '0;
                            busy_q     <= 1'b1;
                            load_cnt_q <= '0;
                            if (!cfg_reuse || !weights_valid_q) begin
                                state_q      <= S_LOAD;
                                load_ena_q   <= 1'b1;
                                load_phase_q <= 1'b0;
                            end else begin
                                state_q   <= S_WAIT_X;
                                x_ready_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (load_done) begin
                            state_q         <= S_WAIT_X;
                            weights_valid_q <= 1'b1;
                            load_ena_q      <= 1'b0;
                            load_phase_q    <= 1'b0;
                            x_ready_q       <= 1'b1;
                        end else if (load_cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
                            state_q         <= S_IDLE;
                            err_q           <= 1'b1;
                            weights_valid_q <= 1'b0;
                            busy_q          <= 1'b0;
                            load_ena_q      <= 1'b0;
                            load_phase_q    <= 1'b0;
                            load_cnt_q      <= '0;
                        end else begin
                            load_cnt_q   <= load_cnt_q + 1'b1;
                            load_phase_q <= ~load_phase_q;
                        end
                    end
                    S_WAIT_X: begin
                        if (x_valid) begin
                            state_q     <= S_RUN;
                            x_ready_q   <= 1'b0;
                            mac_start_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (mac_done) begin
                            state_q     <= S_DRAIN;
                            out_valid_q <= 1'b1;
                            out_sel_q   <= '0;
                            out_last_q  <= (out_len_q == '0);
                        end
                    end
                    S_DRAIN: begin
                        if (out_sel_q == out_len_q) begin
                            out_valid_q <= 1'b0;
                            out_sel_q   <= '0;
                            out_last_q  <= 1'b0;
                            if (vec_idx_q == num_vec_q) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_WAIT_X;
                                vec_idx_q <= vec_idx_q + 8'd1;
                                x_ready_q <= 1'b1;
                            end
                        end else begin
                            out_sel_q  <= out_sel_q + 1'b1;
                            out_last_q <= ((out_sel_q + 1'b1) == out_len_q);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign load_ena   = load_ena_q;
    assign load_phase = load_phase_q;
    assign load_param = {in_len_q, out_len_q};
    assign x_ready    = x_ready_q;
    assign mac_start  = mac_start_q;
    assign out_valid  = out_valid_q;
    assign out_sel    = out_sel_q;
    assign out_last   = out_last_q;
    assign vec_idx    = vec_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: doc/ternary_seq_ctrl.md
TERNARY_SEQ_CTRL -- requirements
Module: ternary_seq_ctrl

Interface
REQ-001 Parameter MAX_IN_LEN, default 16: maximum weight rows; cfg_in_len range 0..MAX_IN_LEN-1.
REQ-002 Parameter MAX_OUT_LEN, default 8: maximum weight columns; cfg_out_len range 0..MAX_OUT_LEN-1.
REQ-003 Parameter LOAD_TIMEOUT, default 64: maximum cycles in LOAD before abort-with-error.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cfg_valid  in  1  start request; sampled only in IDLE.
REQ-007 cfg_in_len  in  4  rows minus 1.
REQ-008 cfg_out_len  in  3  columns minus 1.
REQ-009 cfg_num_vec  in  8  input vectors per job minus 1.
REQ-010 cfg_reuse  in  1  1 = skip LOAD when stored weights are valid.
REQ-011 abort  in  1  synchronous abort, any state.
REQ-012 load_ena  out  1  enable to the weight loader.
REQ-013 load_phase  out  1  0 = host drives MSB plane, 1 = LSB plane.
REQ-014 load_param  out  7  {latched cfg_in_len, latched cfg_out_len} to the loader.
REQ-015 load_done  in  1  loader completion pulse.
REQ-016 x_ready  out  1  controller waiting for an input vector.
REQ-017 x_valid  in  1  host presents an input vector.
REQ-018 mac_start  out  1  one-cycle start pulse to the ternary MAC datapath.
REQ-019 mac_done  in  1  MAC result-ready pulse.
REQ-020 out_valid  out  1  out_sel is a valid result column.
REQ-021 out_sel  out  3  result column index being emitted.
REQ-022 out_last  out  1  final column of the current vector.
REQ-023 vec_idx  out  8  index of the vector in progress.
REQ-024 busy, done, err  out  1 each  job active / one-cycle completion pulse / one-cycle timeout pulse.

Function
REQ-025 All outputs SHALL be registered; states: IDLE, LOAD, WAIT_X, RUN, DRAIN.
REQ-026 In IDLE, cfg_valid=1 SHALL latch all cfg_* inputs, clear vec_idx, set busy, and enter LOAD if cfg_reuse=0 or weights_valid=0, else WAIT_X.
REQ-027 cfg_valid outside IDLE SHALL be ignored; latched config SHALL NOT change mid-job.
REQ-028 In LOAD, load_ena SHALL be 1 every cycle; load_phase SHALL be 0 in the first LOAD cycle and toggle every cycle thereafter.
REQ-029 On the edge where load_done=1 in LOAD, the FSM SHALL enter WAIT_X, set weights_valid, and drive load_ena=0 and load_phase=0 from the next cycle; the load_done cycle itself keeps load_ena=1 so the final LSB plane is captured.
REQ-030 A LOAD cycle counter SHALL reach LOAD_TIMEOUT without load_done -> IDLE, err=1 for one cycle, weights_valid=0, busy=0.
REQ-031 In WAIT_X, x_ready SHALL be 1; x_valid=1 SHALL move to RUN with x_ready=0 and mac_start=1 for exactly the first RUN cycle.
REQ-032 In RUN, mac_done=1 SHALL move to DRAIN; mac_done in any other state SHALL be ignored.
REQ-033 DRAIN SHALL emit out_valid=1 for cfg_out_len+1 consecutive cycles with out_sel 0,1,...,cfg_out_len; out_last=1 only with out_sel=cfg_out_len.
REQ-034 After the last DRAIN cycle: if vec_idx=cfg_num_vec, enter IDLE with done=1 for one cycle and busy=0; else increment vec_idx and enter WAIT_X.
REQ-035 vec_idx SHALL NOT wrap; cfg_num_vec=255 processes 256 vectors, final vec_idx=255.
REQ-036 abort=1 SHALL, from any state, enter IDLE next cycle with all outputs 0, no done or err pulse; abort in LOAD SHALL clear weights_valid; abort outside LOAD SHALL preserve it.
REQ-037 abort SHALL take priority over cfg_valid, load_done, x_valid and mac_done in the same cycle.

Reset
REQ-038 rst_n=0 SHALL force IDLE, weights_valid=0, counters 0, and every output 0 (including load_param) on the next edge, overriding abort and all inputs.
REQ-039 Reset asserted mid-job SHALL discard the job with no done or err pulse.

Verification
REQ-040 in_len=15, out_len=7, num_vec=0, reuse=0; load_done 15 cycles after LOAD entry -> load_ena high 16 cycles, load_phase 0,1,...,1, WAIT_X follows.
REQ-041 x_valid, then mac_done 3 cycles later -> mac_start single pulse, out_sel 0..7, out_last with 7, done pulse, busy low.
REQ-042 Second job reuse=1 -> no load_ena, x_ready asserted next cycle; repeat after abort in LOAD -> LOAD re-entered.
REQ-043 load_done never asserted -> err pulse at cycle 64 of LOAD, weights_valid=0.
REQ-044 num_vec=2, out_len=0 -> three WAIT_X/RUN/DRAIN rounds, vec_idx 0,1,2, one out_valid cycle per vector, one done pulse.
REQ-045 abort and mac_done in the same RUN cycle -> IDLE, out_valid never asserted; rst_n low mid-DRAIN -> all outputs 0 next cycle.
